// File: rtl/mem_responder.sv
// mem_responder - single-word memory responder with wait states and a preload port.
// Optional MMIO switch/LED decode is enabled by defining MEM_MMIO_EN.
module mem_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SW_ADDR     = 'h40,
  parameter int unsigned LED_ADDR    = 'h41
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              ready_q, ready_d;
  logic [7:0]        led_q, led_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              cmd_valid;
  logic              resp_go;
  logic              resp_wr;
  logic [ADDR_W-1:0] resp_addr;
  logic [DATA_W-1:0] resp_data;

  assign cmd_valid = (mem_cmd == 2'b01) || (mem_cmd == 2'b10);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    ready_d     = 1'b0;
    led_d       = led_q;
    mem_we      = 1'b0;
    mem_waddr   = load_addr;
    mem_wdata   = load_data;
    resp_go     = 1'b0;
    resp_wr     = wr_q;
    resp_addr   = addr_q;
    resp_data   = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          mem_we = 1'b1;
        end else if (cmd_valid && reset) begin
          wr_d    = mem_cmd[1];
          addr_d  = mem_addr;
          wdata_d = write_data;
          // With no wait states the response is taken straight from the request.
          if (WAIT_CYCLES == 0) begin
            resp_go   = 1'b1;
            resp_wr   = mem_cmd[1];
            resp_addr = mem_addr;
            resp_data = write_data;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) resp_go = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (resp_go) begin
      state_d = S_RESP;
      ready_d = 1'b1;
      cnt_d   = 4'd0;
      if (resp_wr) begin
`ifdef MEM_MMIO_EN
        if (resp_addr == ADDR_W'(LED_ADDR)) begin
          led_d = resp_data[7:0];
        end else begin
          mem_we    = 1'b1;
          mem_waddr = resp_addr;
          mem_wdata = resp_data;
        end
`else
        mem_we    = 1'b1;
        mem_waddr = resp_addr;
        mem_wdata = resp_data;
`endif
      end else begin
`ifdef MEM_MMIO_EN
        if (resp_addr == ADDR_W'(SW_ADDR)) read_data_d = {{(DATA_W-8){1'b0}}, sw_in};
        else                               read_data_d = mem_q[resp_addr];
`else
        read_data_d = mem_q[resp_addr];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      led_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      led_q       <= led_d;
    end
  end

  // Array contents survive reset, so this port has no reset term.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign read_data = read_data_q;
  assign mem_ready = ready_q;
  assign busy      = (state_q != S_IDLE);

`ifdef MEM_MMIO_EN
  assign led_out = led_q;
`else
  logic unused_mmio;
  assign unused_mmio = ^{sw_in, led_q, SW_ADDR[0], LED_ADDR[0]};
  assign led_out     = 8'd0;
`endif

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's load/store and fetch interface.
- Accepts single-word read/write commands, inserts a parameterised number of wait states, and answers with a one-cycle ready pulse plus registered read data.
- Holds the program/data word array (16-bit words, 8-bit word address).
- Provides a load port so the bench or a boot loader can preload instructions before the CPU runs.

Parameters:
DATA_W, 16, word width
ADDR_W, 8, word-address width; array depth 2**ADDR_W
WAIT_CYCLES, 1, wait states inserted between accept and response (0..15)
SW_ADDR, 8'h40, MMIO switch-read address (used only with MEM_MMIO_EN)
LED_ADDR, 8'h41, MMIO LED-write address (used only with MEM_MMIO_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_cmd  input  2  00 none, 01 read, 10 write, 11 reserved (treated as none)
mem_addr  input  ADDR_W  word address of command
write_data  input  DATA_W  store data
read_data  output  DATA_W  registered load data
mem_ready  output  1  one-cycle completion pulse
busy  output  1  high whenever state is not IDLE
load_en  input  1  preload write strobe
load_addr  input  ADDR_W  preload address
load_data  input  DATA_W  preload data
sw_in  input  8  switch inputs (MMIO)
led_out  output  8  LED register (MMIO)

Behaviour:
Reset (reset=0, asynchronous):
- State IDLE; read_data=0; mem_ready=0; led_out=0; wait counter=0.
- Array contents are not cleared.
- Reset asserted mid-transaction aborts it: no array write, no mem_ready.

States and transitions:
- IDLE:
  - load_en=1: array[load_addr]<=load_data at this edge; mem_cmd ignored this cycle.
  - Else mem_cmd 01/10: latch cmd, addr, data ("accept edge").
  - Go to WAIT with counter=WAIT_CYCLES; if WAIT_CYCLES=0, go directly to RESP.
- WAIT:
  - Counter decrements each edge.
  - Edge where counter reaches 0 moves to RESP.
  - mem_cmd and load_en ignored.
- Edge entering RESP:
  - Write: array[addr]<=data.
  - Read: read_data<=array[addr].
- RESP:
  - mem_ready=1 for exactly this cycle.
  - Unconditional return to IDLE next edge.
  - mem_cmd ignored during RESP.

Timing and handshake:
- Latency: mem_ready is high during the cycle that begins WAIT_CYCLES+1 edges after the accept edge (WAIT_CYCLES=0: the cycle right after accept).
- Requester holds mem_cmd/mem_addr/write_data stable until mem_ready.
- A command still asserted in the IDLE cycle following RESP is accepted as a new transaction.
- read_data holds its value until the next completed read; writes do not disturb it.
- Back-to-back throughput: one transaction per WAIT_CYCLES+2 cycles.
- busy = (state != IDLE).
- Full ADDR_W range is valid; there is no out-of-range error.
- Read of an address written earlier in the same cycle as load_en cannot occur, because load is IDLE-only.

Optional Feature:
MEM_MMIO_EN
- Defined:
  - A read at SW_ADDR returns {(DATA_W-8) zeros, sw_in} sampled on the RESP-entry edge.
  - A write at LED_ADDR sets led_out<=write_data[7:0] on the RESP-entry edge.
  - The array is not written at LED_ADDR, and SW_ADDR is not read from the array.
  - The load port still writes the array at either address.
- Undefined:
  - led_out is tied to 0 and sw_in is unused.
  - SW_ADDR and LED_ADDR behave as ordinary array locations.

Test Plan:
- Reset with load_en preloading addr 8'h00=16'hD105 (MOV R1,#5), then read 8'h00 with WAIT_CYCLES=1 -> mem_ready high exactly 2 cycles after accept edge, read_data=16'hD105, busy high for 2 cycles.
- Write 16'hBEEF to 8'h10, then read 8'h10 -> read_data=16'hBEEF; read_data unchanged (16'hD105) during/after the write.
- WAIT_CYCLES=0 build: hold mem_cmd=01 continuously at 8'h00 -> mem_ready pulses every 2 cycles, each a new transaction.
- Assert reset low during WAIT of a write of 16'h1234 to 8'h20 -> mem_ready never pulses, state IDLE, subsequent read of 8'h20 returns prior contents.
- load_en and mem_cmd=10 asserted together in IDLE -> only the load writes, busy stays 0; load_en during WAIT is ignored (target address unchanged).
- MEM_MMIO_EN: sw_in=8'hA5, read 8'h40 -> read_data=16'h00A5; write 16'h123C to 8'h41 -> led_out=8'h3C, array[8'h41] unchanged. Without macro: same write stores to array, led_out stays 0.
